relay_bank_ctrl: RTL
====================

// Module: relay_bank_ctrl
// PURPOSE
//  Parametrised multi-channel relay/switch controller, the digital successor of the single
//  voltage-controlled hysteresis switch and single timed switch device models.
//  Each of CH channels is either a hysteresis comparator on a sampled control value or a
//  periodic timed toggle. Every contact change passes through a fixed settle interval.
//  Completed transitions are reported on a serialised event port to the mixed-signal harness.
// PARAMETERS
//  CH      4    number of channels (1..16)
//  W       12   signed width of control samples and thresholds
//  TW      16   unsigned width of timed-mode period counter
//  SETTLE  8    cycles from transition start to contact change (>=1)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous active-high reset
//  sample_valid  in   1        sample bus valid this cycle
//  sample        in   CH*W     per-channel signed control value, ch i at [i*W +: W]
//  cfg_we        in   1        configuration write strobe
//  cfg_ch        in   4        channel addressed by write
//  cfg_mode      in   1        0 = hysteresis comparator, 1 = timed toggle
//  cfg_vt        in   W        signed threshold
//  cfg_vh        in   W        signed hysteresis half-width (negative values treated as 0)
//  cfg_time      in   TW       timed-mode period in cycles; 0 = never toggle
//  cfg_init      in   1        forced contact state applied on write
//  closed        out  CH       contact state per channel (1 = closed)
//  busy          out  CH       channel in CLOSING/OPENING
//  event_valid   out  1        one-cycle pulse: a transition completed
//  event_ch      out  4        channel of reported event
//  event_closed  out  1        new contact state of reported event
// BEHAVIOUR
//  Reset (async, immediate): all channels OPEN. closed=0, busy=0, event_valid=0, event_ch=0,
//   event_closed=0. All config fields 0 (mode 0), timers 0, pending bits 0.
//  Per-channel FSM: OPEN -> CLOSING -> CLOSED -> OPENING -> OPEN.
//   Entering CLOSING/OPENING loads settle count SETTLE-1. busy=1 while in these states.
//   At count 0 the next edge changes state, updates closed, and sets the channel pending bit.
//   Contact change occurs exactly SETTLE cycles after the start edge.
//  Mode 0, evaluated only on sample_valid cycles, in OPEN/CLOSED states:
//   Compare in W+2-bit signed arithmetic; no overflow.
//   OPEN and sample > vt+vh -> CLOSING. CLOSED and sample < vt-vh -> OPENING.
//   Equality never triggers. Samples during busy are ignored; transitions are never aborted.
//  Mode 1: the timer increments every cycle.
//   When timer == cfg_time-1, timer clears and a toggle request is raised.
//   The request starts the opposite transition if the channel is not busy; otherwise it is dropped.
//   With cfg_time == 0 the timer is held at 0.
//  Config write (cfg_we, cfg_ch < CH; writes with cfg_ch >= CH are ignored):
//   Fields latch at the edge and take effect on the next cycle.
//   State is forced to CLOSED if cfg_init=1, else OPEN. Any transition in progress is aborted.
//   Timer clears and the pending bit clears. No event is generated.
//   A write and a completion on the same channel in the same cycle: the write wins.
//  Event port (registered):
//   Each cycle, if any pending bit is set, report the lowest-index pending channel.
//   event_valid=1, event_ch=idx, event_closed=closed[idx]; that bit clears.
//   At most one event per cycle; remaining bits are reported in later cycles.
//   A new completion on a channel whose pending bit is still set overwrites it (one event, latest state).
//   A bit set and served in the same cycle is not lost: set takes priority over clear.
// TESTING
//  T1 reset: assert rst mid-CLOSING on ch0 -> closed=0, busy=0, event_valid=0 immediately.
//   No event after release.
//  T2 hysteresis, ch1 vt=100 vh=10, SETTLE=8: sample 110 -> no change; 111 -> busy 8 cycles.
//   Then closed[1]=1 and an event for ch1 with closed=1. Then 95 -> stays closed; 89 -> opens.
//  T3 overflow: W=12, vt=2047 vh=2047 -> sample 2047 never closes.
//   vt=-2048 vh=2047 with ch CLOSED -> sample -2048 never opens.
//  T4 timed: ch2 mode 1, cfg_time=20 -> toggles start every 20 cycles.
//   closed[2] alternates; events every 20 cycles.
//  T5 simultaneous: ch0 and ch3 complete on the same edge -> ch0 event, ch3 event next cycle.
//  T6 config abort: write ch1 init=1 during OPENING -> next cycle closed[1]=1, busy[1]=0.
//   Pending bit cleared; no event.

Source files
------------

// File: rtl/relay_bank_ctrl.sv
// Multi-channel relay controller: each channel is a hysteresis comparator or a timed toggle,
// every contact change passes a fixed settle interval, completions are reported one per cycle.
module relay_bank_ctrl #(
    parameter int unsigned CH     = 4,
    parameter int unsigned W      = 12,
    parameter int unsigned TW     = 16,
    parameter int unsigned SETTLE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_valid,
    input  logic [CH*W-1:0] sample,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_ch,
    input  logic            cfg_mode,
    input  logic [W-1:0]    cfg_vt,
    input  logic [W-1:0]    cfg_vh,
    input  logic [TW-1:0]   cfg_time,
    input  logic            cfg_init,
    output logic [CH-1:0]   closed,
    output logic [CH-1:0]   busy,
    output logic            event_valid,
    output logic [3:0]      event_ch,
    output logic            event_closed
);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned XW = W + 2;

    typedef enum logic [1:0] {ST_OPEN, ST_CLOSING, ST_CLOSED, ST_OPENING} state_t;

    state_t               state  [CH];
    logic [CW-1:0]        cnt    [CH];
    logic [TW-1:0]        timer  [CH];
    logic                 mode   [CH];
    logic [W-1:0]         vt     [CH];
    logic [W-1:0]         vh     [CH];
    logic [TW-1:0]        period [CH];
    logic [CH-1:0]        pending;

    logic signed [XW-1:0] smp_x  [CH];
    logic signed [XW-1:0] vt_x   [CH];
    logic signed [XW-1:0] vh_x   [CH];
    logic signed [XW-1:0] thr_hi [CH];
    logic signed [XW-1:0] thr_lo [CH];
    logic [CH-1:0]        wr_hit;
    logic [CH-1:0]        tick;
    logic [CH-1:0]        start;
    logic [CH-1:0]        done;
    logic [CH-1:0]        ev_mask;
    logic                 ev_hit;
    logic                 ev_cl;
    logic [3:0]           ev_idx;

    // Per-channel thresholds (widened so vt +/- vh cannot wrap), timer tick and start/finish
    always_comb begin
        wr_hit = '0;
        tick   = '0;
        start  = '0;
        done   = '0;
        for (int i = 0; i < int'(CH); i++) begin
            smp_x[i]  = {{2{sample[i*W+W-1]}}, sample[i*W +: W]};
            vt_x[i]   = {{2{vt[i][W-1]}}, vt[i]};
            vh_x[i]   = vh[i][W-1] ? '0 : {2'b00, vh[i]};
            thr_hi[i] = vt_x[i] + vh_x[i];
            thr_lo[i] = vt_x[i] - vh_x[i];
            wr_hit[i] = cfg_we && (cfg_ch == 4'(i));
            tick[i]   = mode[i] && (period[i] != '0) && (timer[i] == period[i] - TW'(1));
            done[i]   = ((state[i] == ST_CLOSING) || (state[i] == ST_OPENING)) && (cnt[i] == '0);
            if (state[i] == ST_OPEN)
                start[i] = mode[i] ? tick[i] : (sample_valid && (smp_x[i] > thr_hi[i]));
            else if (state[i] == ST_CLOSED)
                start[i] = mode[i] ? tick[i] : (sample_valid && (smp_x[i] < thr_lo[i]));
        end
    end

    // Lowest-index pending channel; a channel being rewritten this cycle is not reported
    always_comb begin
        ev_hit  = 1'b0;
        ev_idx  = '0;
        ev_cl   = 1'b0;
        ev_mask = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (pending[i] && !wr_hit[i]) begin
                ev_hit     = 1'b1;
                ev_idx     = 4'(i);
                ev_cl      = closed[i];
                ev_mask    = '0;
                ev_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(CH); i++) begin
                state[i]  <= ST_OPEN;
                cnt[i]    <= '0;
                timer[i]  <= '0;
                mode[i]   <= 1'b0;
                vt[i]     <= '0;
                vh[i]     <= '0;
                period[i] <= '0;
            end
            closed       <= '0;
            busy         <= '0;
            pending      <= '0;
            event_valid  <= 1'b0;
            event_ch     <= '0;
            event_closed <= 1'b0;
        end else begin
            event_valid <= ev_hit;
            if (ev_hit) begin
                event_ch     <= ev_idx;
                event_closed <= ev_cl;
            end
            // New completions beat the serve-clear; a config write beats both
            pending <= ((pending & ~ev_mask) | done) & ~wr_hit;
            for (int i = 0; i < int'(CH); i++) begin
                if (wr_hit[i]) begin
                    mode[i]   <= cfg_mode;
                    vt[i]     <= cfg_vt;
                    vh[i]     <= cfg_vh;
                    period[i] <= cfg_time;
                    timer[i]  <= '0;
                    cnt[i]    <= '0;
                    state[i]  <= cfg_init ? ST_CLOSED : ST_OPEN;
                    closed[i] <= cfg_init;
                    busy[i]   <= 1'b0;
                end else begin
                    if (mode[i] && (period[i] != '0))
                        timer[i] <= tick[i] ? '0 : timer[i] + TW'(1);
                    else
                        timer[i] <= '0;
                    if (start[i]) begin
                        state[i] <= (state[i] == ST_OPEN) ? ST_CLOSING : ST_OPENING;
                        cnt[i]   <= CW'(SETTLE - 1);
                        busy[i]  <= 1'b1;
                    end else if (done[i]) begin
                        state[i]  <= (state[i] == ST_CLOSING) ? ST_CLOSED : ST_OPEN;
                        closed[i] <= (state[i] == ST_CLOSING);
                        busy[i]   <= 1'b0;
                    end else if (busy[i]) begin
                        cnt[i] <= cnt[i] - CW'(1);
                    end
                end
            end
        end
    end
endmodule
